muldiv_seq_ctrl: RTL
====================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Sequencer for the RV64 M-extension ops flagged by decode (alu_info[12:0]). Accepts one op at a time
//  over a valid/ready handshake and runs a radix-2 iterative shift-add multiply or restoring divide.
//  Resolves divide corner cases, then holds the result until writeback takes it.
//  Sits beside the single-cycle ALU in execute; in_ready low stalls the front end.
// PARAMETERS
//  XLEN  64  operand/result width
//  OPW   13  one-hot op vector width
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous, active-low reset
//  flush      in   1     discard in-flight op (pipeline redirect)
//  in_valid   in   1     op request
//  in_ready   out  1     block can accept (IDLE only)
//  in_op      in   13    one-hot: [12]mul [11]mulh [10]mulhsu [9]mulhu [8]div [7]divu [6]rem [5]remu
//                        [4]mulw [3]divw [2]divuw [1]remw [0]remuw
//  in_src1    in   XLEN  rs1 value
//  in_src2    in   XLEN  rs2 value
//  in_rd      in   5     destination register
//  out_valid  out  1     result available (DONE only)
//  out_ready  in   1     consumer takes result
//  out_result out  XLEN  result
//  out_rd     out  5     destination of result
//  busy       out  1     ~IDLE; for hazard/stall logic
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, in_ready=1, out_valid=0, busy=0; out_result=0 and out_rd=0.
//  Accept: in IDLE, in_valid & |in_op at the edge. If in_op is multi-hot, the highest set bit wins.
//          in_valid with in_op==0 is ignored.
//  FSM: IDLE -> PREP -> CALC(N cycles) -> FIX -> DONE -> IDLE.
//       N = 64 for 64-bit ops; N = 32 for W ops.
//   PREP: latch operands. Take absolute values for signed ops (mulh: both operands; mulhsu: src1 only;
//         div/rem: both). Record the result sign. W ops use src[31:0], sign- or zero-extended per op.
//         Div-by-zero or signed overflow (MIN / -1) detected here -> go straight to FIX.
//   CALC: one iteration per cycle on a 2*XLEN accumulator; counter counts down to 0, then FIX.
//   FIX: apply sign correction and select the result.
//        mul/mulw take the low half; mulh* take the high half; div* take the quotient; rem* take the remainder.
//        W results are sign-extended from bit 31.
//   DONE: out_valid=1. out_result and out_rd stay stable until out_ready; out_valid & out_ready -> IDLE.
//  Latency: accept in cycle k -> out_valid first high in cycle k+N+3; corner cases in cycle k+3.
//  Throughput: no new accept in the DONE->IDLE handoff cycle; next accept is possible 1 cycle later.
//  Corner results (match the RISC-V spec):
//   - x/0: quotient = all ones (W: sext 32'hFFFF_FFFF); remainder = dividend (W: sext src1[31:0]).
//   - MIN/-1: quotient = MIN (W: sext 32'h8000_0000); remainder = 0.
//  flush=1 at an edge: next state IDLE, out_valid=0, op discarded. Flush wins over a same-cycle accept
//  and over a same-cycle out_ready handshake (result dropped). Reset mid-op behaves the same.
//  Signed negation is two's complement in XLEN (W: 32) bits; MIN magnitude is handled as unsigned.
// STRUCTURE
//  muldiv_pkg: op-bit index localparams (OP_MUL=12 .. OP_REMUW=0), FSM state encoding
//   (IDLE/PREP/CALC/FIX/DONE), and width constants.
//  One sub-module, muldiv_iter_core: accumulator/quotient registers and a single add/sub-shift step.
//   Controlled by load/step/mode from this FSM. Sign/fixup and handshake logic stay in this module.
// TESTING
//  1. mul 7 * -3 (src2 = 64'hFFFF_FFFF_FFFF_FFFD) -> out_result 64'hFFFF_FFFF_FFFF_FFEB;
//     out_valid first in cycle k+67.
//  2. div 100 / 0 -> 64'hFFFF_FFFF_FFFF_FFFF at k+3; rem 100 / 0 -> 64'd100 at k+3.
//  3. div 64'h8000_0000_0000_0000 / -1 -> 64'h8000_0000_0000_0000; rem on the same operands -> 0; both at k+3.
//  4. mulw 32'h7FFF_FFFF * 2 -> 64'hFFFF_FFFF_FFFF_FFFE at k+35.
//     divuw 32'hFFFF_FFFF / 1 -> 64'hFFFF_FFFF_FFFF_FFFF.
//  5. mulhu all-ones * all-ones -> 64'hFFFF_FFFF_FFFF_FFFE. With out_ready held low 5 cycles:
//     out_valid, out_result and out_rd are stable, in_ready=0, and a second in_valid is not accepted.
//  6. flush during CALC iteration 10 -> IDLE next cycle, in_ready=1, no out_valid ever.
//     Repeat with rst=0 mid-CALC -> all outputs at reset values.
//     A flush in the same cycle as in_valid in IDLE -> no accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, op decode and FSM encoding for the M-extension multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;
    localparam int unsigned OPW  = 13;
    localparam int unsigned ACCW = 2 * XLEN;
    localparam int unsigned CNTW = 6;
    localparam int unsigned RDW  = 5;

    localparam int unsigned OP_MUL    = 12;
    localparam int unsigned OP_MULH   = 11;
    localparam int unsigned OP_MULHSU = 10;
    localparam int unsigned OP_MULHU  = 9;
    localparam int unsigned OP_DIV    = 8;
    localparam int unsigned OP_DIVU   = 7;
    localparam int unsigned OP_REM    = 6;
    localparam int unsigned OP_REMU   = 5;
    localparam int unsigned OP_MULW   = 4;
    localparam int unsigned OP_DIVW   = 3;
    localparam int unsigned OP_DIVUW  = 2;
    localparam int unsigned OP_REMW   = 1;
    localparam int unsigned OP_REMUW  = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic is_div;
        logic is_word;
        logic sgn1;
        logic sgn2;
        logic hi_half;
        logic take_rem;
    } op_info_t;

    // Highest set op bit wins when the vector is multi-hot.
    function automatic op_info_t decode_op(input logic [OPW-1:0] op);
        op_info_t info;
        info = '0;
        if (op[OP_MUL]) begin
            info = '0;
        end else if (op[OP_MULH]) begin
            info.sgn1 = 1'b1; info.sgn2 = 1'b1; info.hi_half = 1'b1;
        end else if (op[OP_MULHSU]) begin
            info.sgn1 = 1'b1; info.hi_half = 1'b1;
        end else if (op[OP_MULHU]) begin
            info.hi_half = 1'b1;
        end else if (op[OP_DIV]) begin
            info.is_div = 1'b1; info.sgn1 = 1'b1; info.sgn2 = 1'b1;
        end else if (op[OP_DIVU]) begin
            info.is_div = 1'b1;
        end else if (op[OP_REM]) begin
            info.is_div = 1'b1; info.sgn1 = 1'b1; info.sgn2 = 1'b1; info.take_rem = 1'b1;
        end else if (op[OP_REMU]) begin
            info.is_div = 1'b1; info.take_rem = 1'b1;
        end else if (op[OP_MULW]) begin
            info.is_word = 1'b1;
        end else if (op[OP_DIVW]) begin
            info.is_div = 1'b1; info.is_word = 1'b1; info.sgn1 = 1'b1; info.sgn2 = 1'b1;
        end else if (op[OP_DIVUW]) begin
            info.is_div = 1'b1; info.is_word = 1'b1;
        end else if (op[OP_REMW]) begin
            info.is_div = 1'b1; info.is_word = 1'b1; info.sgn1 = 1'b1; info.sgn2 = 1'b1;
            info.take_rem = 1'b1;
        end else if (op[OP_REMUW]) begin
            info.is_div = 1'b1; info.is_word = 1'b1; info.take_rem = 1'b1;
        end
        return info;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on a {hi,lo} accumulator.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] load_lo,
    input  logic [XLEN-1:0] load_opnd,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        sum    = {1'b0, hi_q} + {1'b0, opnd_q};
        rem_sh = {hi_q, lo_q[XLEN-1]};
        ge     = (rem_sh >= {1'b0, opnd_q});
        // Only taken when ge, where the true difference fits in XLEN bits.
        diff   = rem_sh[XLEN-1:0] - opnd_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = load_lo;
            opnd_d = load_opnd;
        end else if (step) begin
            if (div_mode) begin
                hi_d = ge ? diff : rem_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ge};
            end else if (lo_q[0]) begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end else begin
                hi_d = {1'b0, hi_q[XLEN-1:1]};
                lo_d = {hi_q[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// M-extension sequencer: handshake, operand prep, divide corner cases and result fixup
// around the iterative multiply/divide core.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RDW-1:0]  in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RDW-1:0]  out_rd,
    output logic            busy
);

    logic [2:0]      state_q, state_d;
    op_info_t        info_q, info_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [RDW-1:0]  rd_q, rd_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [RDW-1:0]  out_rd_q, out_rd_d;

    logic            core_load, core_step;
    logic [XLEN-1:0] core_lo, core_opnd;
    logic [XLEN-1:0] acc_hi, acc_lo;

    logic            neg_a, neg_b, res_neg, is_zero, is_ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [ACCW-1:0] prod, prod_s;
    logic [XLEN-1:0] quo, quo_s, rem_s, div_sel, dvd_ext, fix_res;

    muldiv_iter_core u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .div_mode  (info_q.is_div),
        .load_lo   (core_lo),
        .load_opnd (core_opnd),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo)
    );

    // Operand magnitudes, result sign and corner detection from the latched request.
    always_comb begin
        if (info_q.is_word) begin
            neg_a   = info_q.sgn1 & src1_q[WLEN-1];
            neg_b   = info_q.sgn2 & src2_q[WLEN-1];
            mag_a   = {{(XLEN-WLEN){1'b0}}, neg_a ? (~src1_q[WLEN-1:0] + WLEN'(1)) : src1_q[WLEN-1:0]};
            mag_b   = {{(XLEN-WLEN){1'b0}}, neg_b ? (~src2_q[WLEN-1:0] + WLEN'(1)) : src2_q[WLEN-1:0]};
            is_zero = (src2_q[WLEN-1:0] == '0);
            is_ovf  = (src1_q[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}}) && (src2_q[WLEN-1:0] == '1);
            core_lo = info_q.is_div ? {mag_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag_b;
        end else begin
            neg_a   = info_q.sgn1 & src1_q[XLEN-1];
            neg_b   = info_q.sgn2 & src2_q[XLEN-1];
            mag_a   = neg_a ? (~src1_q + XLEN'(1)) : src1_q;
            mag_b   = neg_b ? (~src2_q + XLEN'(1)) : src2_q;
            is_zero = (src2_q == '0);
            is_ovf  = (src1_q == {1'b1, {(XLEN-1){1'b0}}}) && (src2_q == '1);
            core_lo = info_q.is_div ? mag_a : mag_b;
        end
        is_ovf    = is_ovf & info_q.is_div & info_q.sgn1;
        core_opnd = info_q.is_div ? mag_b : mag_a;
        res_neg   = (info_q.is_div && info_q.take_rem) ? neg_a : (neg_a ^ neg_b);
    end

    // Final result selection once the iterations are complete.
    always_comb begin
        prod    = {acc_hi, acc_lo};
        prod_s  = neg_q ? (~prod + ACCW'(1)) : prod;
        quo     = info_q.is_word ? {{(XLEN-WLEN){1'b0}}, acc_lo[WLEN-1:0]} : acc_lo;
        quo_s   = neg_q ? (~quo + XLEN'(1)) : quo;
        rem_s   = neg_q ? (~acc_hi + XLEN'(1)) : acc_hi;
        div_sel = info_q.take_rem ? rem_s : quo_s;
        dvd_ext = info_q.is_word ? sext32(src1_q[WLEN-1:0]) : src1_q;
        fix_res = '0;
        if (div0_q) begin
            fix_res = info_q.take_rem ? dvd_ext : '1;
        end else if (ovf_q) begin
            fix_res = info_q.take_rem ? '0 : dvd_ext;
        end else if (info_q.is_div) begin
            fix_res = info_q.is_word ? sext32(div_sel[WLEN-1:0]) : div_sel;
        end else if (info_q.is_word) begin
            // 32 right shifts leave the W product at acc[95:32].
            fix_res = sext32(acc_lo[XLEN-1:XLEN-WLEN]);
        end else if (info_q.hi_half) begin
            fix_res = prod_s[ACCW-1:XLEN];
        end else begin
            fix_res = prod_s[XLEN-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        info_d       = info_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        div0_d       = div0_q;
        ovf_d        = ovf_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        core_load    = 1'b0;
        core_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && (|in_op)) begin
                    info_d  = decode_op(in_op);
                    src1_d  = in_src1;
                    src2_d  = in_src2;
                    rd_d    = in_rd;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                core_load = 1'b1;
                neg_d     = res_neg;
                div0_d    = info_q.is_div & is_zero;
                ovf_d     = is_ovf;
                cnt_d     = info_q.is_word ? CNTW'(WLEN - 1) : CNTW'(XLEN - 1);
                state_d   = (info_q.is_div && (is_zero || is_ovf)) ? ST_FIX : ST_CALC;
            end
            ST_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_result_d = fix_res;
                out_rd_d     = rd_q;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            out_result_d = out_result_q;
            out_rd_d     = out_rd_q;
        end
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            info_q       <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            div0_q       <= 1'b0;
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            info_q       <= info_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            div0_q       <= div0_d;
            ovf_q        <= ovf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

endmodule
